sdram_responder: RTL and testbench
==================================

SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 The module SHALL have parameter MEM_ADDR_BITS, default 10, meaning log2 of stored 16-bit words.
REQ-002 The module SHALL have parameter INHIBIT_CYCLES, default 16'd33333, meaning the minimum clk cycles of INHIBIT/NOP before the first command.
REQ-003 The module SHALL have parameter INIT_REFRESHES, default 16'd8, meaning the REFRESH commands required before READY.
REQ-004 The module SHALL have parameters PRECHARGE_CYCLES (default 16'd2, tRP), REFRESH_CYCLES (default 16'd9, tRC) and ACTIVATE_CYCLES (default 16'd2, tRCD), in clk cycles.
REQ-005 The module SHALL have these ports, in order:
- clk, input, 1, 166.666 MHz clock; the same clock as sdram_clk.
- reset, input, 1, synchronous, active-high.
- sdram_addr, input, 13, address bus.
- sdram_bs, input, 2, bank select.
- sdram_data, inout, 16, data bus; driven only during read data cycles.
- sdram_cs, sdram_ras, sdram_cas, sdram_we, inputs, 1 each, command pins.
- sdram_dqm, input, 2, byte masks; bit1 masks [15:8] and bit0 masks [7:0].
- sdram_cke, input, 1, clock enable.
- ready, output, 1, high once the init sequence is complete.
- cas_latency, output, 2, latched mode CL.
- error, output, 1, sticky protocol/timing violation flag.
- error_code, output, 4, code of the first violation.
- refresh_count, output, 16, REFRESH commands accepted since reset.

Function
REQ-006 Commands SHALL be decoded as {cs,ras,cas,we} sampled at the posedge: 0111 NOP, 0011 ACTIVATE, 0101 READ, 0100 WRITE, 0010 PRECHARGE, 0001 REFRESH, 0000 MODE, 1xxx INHIBIT. Commands SHALL be ignored when sdram_cke=0.
REQ-007 The init FSM SHALL run POWERUP -> WAIT_PRECHARGE -> WAIT_MODE -> WAIT_REFRESH -> READY.
- POWERUP counts cycles; any non-INHIBIT/NOP command before INHIBIT_CYCLES SHALL raise error code 1.
- WAIT_PRECHARGE SHALL accept only PRECHARGE with A10=1 (all banks).
- WAIT_MODE SHALL accept MODE after tRP has elapsed.
- WAIT_REFRESH SHALL count INIT_REFRESHES refreshes, each spaced at least tRC apart.
- Any other command in these states SHALL raise error code 2.
REQ-008 MODE SHALL latch A6:A4 as CL. Only values 2 and 3 are supported; any other CL, A2:A0≠000 (burst length ≠ 1) or A9=0 SHALL raise error code 3.
REQ-009 The module SHALL keep a per-bank state (IDLE/ACTIVE), an open row (13b) and a tRCD counter.
- ACTIVATE to an ACTIVE bank SHALL raise error code 4.
- READ/WRITE to an IDLE bank SHALL raise error code 5.
- READ/WRITE before ACTIVATE_CYCLES have elapsed SHALL raise error code 6.
REQ-010 READ/WRITE with A10=1 SHALL return the bank to IDLE one cycle after the command. A10=0 SHALL leave the bank ACTIVE.
REQ-011 REFRESH or MODE while any bank is ACTIVE SHALL raise error code 7. Any command within REFRESH_CYCLES of a REFRESH (NOP/INHIBIT excepted) SHALL raise error code 8.
REQ-012 The word address SHALL be {bank, row, col[8:0]} truncated to its low MEM_ADDR_BITS bits; this wrap-around is intentional.
REQ-013 WRITE SHALL capture sdram_data in the command cycle and update only the bytes whose DQM bit is 0. DQM=11 SHALL write nothing.
REQ-014 Read path:
- READ SHALL enter a 3-stage valid/address/DQM pipeline.
- Data SHALL be driven on sdram_data during the cycle that starts CL posedges after the command, for exactly one cycle.
- Bytes whose read-command DQM is 1 SHALL stay high-Z.
- Back-to-back READs every cycle SHALL each produce one data cycle.
REQ-015 A WRITE issued while read data is pending SHALL raise error code 9 (bus contention). The write SHALL still be performed.
REQ-016 The error flag and error_code SHALL latch on the first violation only; later violations SHALL NOT change the code. After a violation, state SHALL update as if the command had been legal.
REQ-017 refresh_count SHALL increment on every accepted REFRESH and saturate at 16'hFFFF.

Reset
REQ-018 On reset, all of the following SHALL clear:
- FSM to POWERUP; counters to 0.
- Banks to IDLE; read pipeline invalid; sdram_data high-Z.
- ready=0, cas_latency=2'd3, error=0, error_code=0, refresh_count=0.
Memory contents SHALL NOT clear. Reset asserted mid-read SHALL cancel pending data the next cycle.

Structure
REQ-019 Command encodings, the init state enum, the error-code enum and the bank state enum SHALL live in a shared package, sdram_pkg, which sdram_controller also imports.
REQ-020 The read pipeline SHALL be a sub-module sdram_read_pipe (CL-selectable delay line with valid, address and DQM).

Verification
REQ-021 The bench SHALL cover these directed scenarios, each with INHIBIT_CYCLES=100:
- Legal init (PRECHARGE A10=1, MODE 0x230, 8 REFRESH at 9-cycle spacing) -> ready=1, cas_latency=3, refresh_count=8, error=0.
- WRITE 0xA55A with DQM=10 to bank1/row5/col7 after ACTIVATE, then READ with DQM=00 -> data [7:0]=0x5A appears exactly 3 cycles after READ; [15:8] holds the prior value.
- READ one cycle after ACTIVATE with tRCD=2 -> error=1, error_code=6; a later ACTIVATE to a busy bank leaves code at 6.
- REFRESH at cycle 4 after a previous REFRESH -> error_code=8.
- MODE with CL=2, then READs on consecutive cycles -> one data cycle each, 2 cycles after each command, no gaps.
- Reset asserted the cycle after READ -> sdram_data is high-Z in the next cycle and ready=0.

Source files
------------

// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_pkg
// Purpose  : Shared SDRAM command, init-state, error-code and bank-state types.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    localparam int c_NUM_BANKS = 4;

    typedef enum logic [3:0] {
        CMD_MODE      = 4'b0000,
        CMD_REFRESH   = 4'b0001,
        CMD_PRECHARGE = 4'b0010,
        CMD_ACTIVATE  = 4'b0011,
        CMD_WRITE     = 4'b0100,
        CMD_READ      = 4'b0101,
        CMD_NOP       = 4'b0111,
        CMD_INHIBIT   = 4'b1000
    } cmd_e;

    typedef enum logic [2:0] {
        INIT_POWERUP        = 3'd0,
        INIT_WAIT_PRECHARGE = 3'd1,
        INIT_WAIT_MODE      = 3'd2,
        INIT_WAIT_REFRESH   = 3'd3,
        INIT_READY          = 3'd4
    } init_state_e;

    typedef enum logic [3:0] {
        ERR_NONE       = 4'd0,
        ERR_POWERUP    = 4'd1,
        ERR_INIT_SEQ   = 4'd2,
        ERR_MODE       = 4'd3,
        ERR_ACT_ACTIVE = 4'd4,
        ERR_RW_IDLE    = 4'd5,
        ERR_TRCD       = 4'd6,
        ERR_BANK_OPEN  = 4'd7,
        ERR_TRC        = 4'd8,
        ERR_CONTENTION = 4'd9
    } err_code_e;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_e;

    // With CKE low the pins are ignored, so that looks like a NOP; burst-terminate is unsupported and ignored too.
    function automatic cmd_e decode_cmd(input logic cke, input logic cs, input logic ras,
                                        input logic cas, input logic we);
        cmd_e cmd;
        if (!cke) begin
            cmd = CMD_NOP;
        end else if (cs) begin
            cmd = CMD_INHIBIT;
        end else begin
            case ({ras, cas, we})
                3'b000:  cmd = CMD_MODE;
                3'b001:  cmd = CMD_REFRESH;
                3'b010:  cmd = CMD_PRECHARGE;
                3'b011:  cmd = CMD_ACTIVATE;
                3'b100:  cmd = CMD_WRITE;
                3'b101:  cmd = CMD_READ;
                default: cmd = CMD_NOP;
            endcase
        end
        return cmd;
    endfunction

    // Down-counter preload: a command is legal once the counter reads zero.
    function automatic logic [15:0] wait_load(input logic [15:0] cycles);
        return (cycles == 16'd0) ? 16'd0 : cycles - 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_read_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sdram_read_pipe
// Purpose  : Three-stage valid/address/DQM delay line tapped by CAS latency.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_read_pipe #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [1:0]           i_dqm,
    input  logic [1:0]           i_cl,
    output logic                 o_valid,
    output logic [ADDR_BITS-1:0] o_addr,
    output logic [1:0]           o_dqm,
    output logic                 o_pending
);

    logic [2:0]           r_valid;
    logic [ADDR_BITS-1:0] r_addr [3];
    logic [1:0]           r_dqm  [3];
    logic                 w_tap_late;

    // The owner registers the tap once more, so CL=2 taps stage 1 and CL=3 taps stage 2.
    assign w_tap_late = (i_cl != 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 3'b000;
        end else begin
            r_valid <= {r_valid[1:0], i_push};
        end
    end

    always_ff @(posedge clk) begin
        r_addr[0] <= i_addr;
        r_addr[1] <= r_addr[0];
        r_addr[2] <= r_addr[1];
        r_dqm[0]  <= i_dqm;
        r_dqm[1]  <= r_dqm[0];
        r_dqm[2]  <= r_dqm[1];
    end

    assign o_valid   = w_tap_late ? r_valid[2] : r_valid[1];
    assign o_addr    = w_tap_late ? r_addr[2]  : r_addr[1];
    assign o_dqm     = w_tap_late ? r_dqm[2]   : r_dqm[1];
    assign o_pending = r_valid[0] | r_valid[1] | (w_tap_late & r_valid[2]);

endmodule
`default_nettype wire

// File: rtl/sdram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sdram_responder
// Purpose  : Behavioural SDRAM device model with init/timing/protocol checking.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int          MEM_ADDR_BITS    = 10,
    parameter logic [15:0] INHIBIT_CYCLES   = 16'd33333,
    parameter logic [15:0] INIT_REFRESHES   = 16'd8,
    parameter logic [15:0] PRECHARGE_CYCLES = 16'd2,
    parameter logic [15:0] REFRESH_CYCLES   = 16'd9,
    parameter logic [15:0] ACTIVATE_CYCLES  = 16'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] sdram_addr,
    input  logic [1:0]  sdram_bs,
    inout  wire  [15:0] sdram_data,
    input  logic        sdram_cs,
    input  logic        sdram_ras,
    input  logic        sdram_cas,
    input  logic        sdram_we,
    input  logic [1:0]  sdram_dqm,
    input  logic        sdram_cke,
    output logic        ready,
    output logic [1:0]  cas_latency,
    output logic        error,
    output logic [3:0]  error_code,
    output logic [15:0] refresh_count
);

    init_state_e r_state;
    logic [15:0] r_pwr_cnt;
    logic [15:0] r_ref_init;
    logic [15:0] r_trp_wait;
    logic [15:0] r_trc_wait;
    bank_state_e r_bank_state [c_NUM_BANKS];
    logic [12:0] r_bank_row   [c_NUM_BANKS];
    logic [15:0] r_trcd       [c_NUM_BANKS];
    logic        r_ready;
    logic [1:0]  r_cl;
    logic        r_error;
    err_code_e   r_error_code;
    logic [15:0] r_refresh_count;

    logic [15:0] r_mem [2**MEM_ADDR_BITS];
    logic [15:0] r_dq;
    logic [1:0]  r_drv;
    logic        r_rd_out_valid;

    cmd_e                     w_cmd;
    err_code_e                w_viol;
    logic                     w_is_cmd;
    logic                     w_is_rw;
    logic                     w_mode_ok;
    logic                     w_init_bad;
    logic                     w_any_active;
    logic                     w_bank_idle;
    logic                     w_rd_pending;
    logic [23:0]              w_addr_full;
    logic [MEM_ADDR_BITS-1:0] w_word_addr;
    logic                     w_pipe_valid;
    logic [MEM_ADDR_BITS-1:0] w_pipe_addr;
    logic [1:0]               w_pipe_dqm;
    logic                     w_pipe_pending;

    assign w_cmd       = decode_cmd(sdram_cke, sdram_cs, sdram_ras, sdram_cas, sdram_we);
    assign w_is_cmd    = (w_cmd != CMD_NOP) && (w_cmd != CMD_INHIBIT);
    assign w_is_rw     = (w_cmd == CMD_READ) || (w_cmd == CMD_WRITE);
    assign w_mode_ok   = sdram_addr[9] && (sdram_addr[2:0] == 3'b000) &&
                         ((sdram_addr[6:4] == 3'd2) || (sdram_addr[6:4] == 3'd3));
    assign w_bank_idle = (r_bank_state[sdram_bs] == BANK_IDLE);
    assign w_rd_pending = w_pipe_pending | r_rd_out_valid;
    // Small memories alias the high row/bank bits on purpose.
    assign w_addr_full = {sdram_bs, r_bank_row[sdram_bs], sdram_addr[8:0]};
    assign w_word_addr = MEM_ADDR_BITS'(w_addr_full);

    always_comb begin
        w_any_active = 1'b0;
        for (int b = 0; b < c_NUM_BANKS; b++) begin
            if (r_bank_state[b] == BANK_ACTIVE) w_any_active = 1'b1;
        end
    end

    always_comb begin
        w_init_bad = 1'b0;
        case (r_state)
            INIT_WAIT_PRECHARGE: w_init_bad = !((w_cmd == CMD_PRECHARGE) && sdram_addr[10]);
            INIT_WAIT_MODE:      w_init_bad = !((w_cmd == CMD_MODE) && (r_trp_wait == 16'd0));
            INIT_WAIT_REFRESH:   w_init_bad = (w_cmd != CMD_REFRESH);
            default:             w_init_bad = 1'b0;
        endcase
    end

    always_comb begin
        w_viol = ERR_NONE;
        if (w_is_cmd) begin
            if (r_state == INIT_POWERUP)                                    w_viol = ERR_POWERUP;
            else if (r_trc_wait != 16'd0)                                   w_viol = ERR_TRC;
            else if (w_init_bad)                                            w_viol = ERR_INIT_SEQ;
            else if ((w_cmd == CMD_MODE) && !w_mode_ok)                     w_viol = ERR_MODE;
            else if (((w_cmd == CMD_REFRESH) || (w_cmd == CMD_MODE)) && w_any_active)
                                                                            w_viol = ERR_BANK_OPEN;
            else if ((w_cmd == CMD_ACTIVATE) && !w_bank_idle)               w_viol = ERR_ACT_ACTIVE;
            else if (w_is_rw && w_bank_idle)                                w_viol = ERR_RW_IDLE;
            else if (w_is_rw && (r_trcd[sdram_bs] != 16'd0))                w_viol = ERR_TRCD;
            else if ((w_cmd == CMD_WRITE) && w_rd_pending)                  w_viol = ERR_CONTENTION;
        end
    end

    // Violations are only recorded; every command still updates state as though it were legal.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= INIT_POWERUP;
            r_pwr_cnt       <= 16'd0;
            r_ref_init      <= 16'd0;
            r_trp_wait      <= 16'd0;
            r_trc_wait      <= 16'd0;
            r_ready         <= 1'b0;
            r_cl            <= 2'd3;
            r_error         <= 1'b0;
            r_error_code    <= ERR_NONE;
            r_refresh_count <= 16'd0;
            for (int b = 0; b < c_NUM_BANKS; b++) begin
                r_bank_state[b] <= BANK_IDLE;
                r_bank_row[b]   <= 13'd0;
                r_trcd[b]       <= 16'd0;
            end
        end else begin
            if (r_trp_wait != 16'd0) r_trp_wait <= r_trp_wait - 16'd1;
            if (r_trc_wait != 16'd0) r_trc_wait <= r_trc_wait - 16'd1;
            for (int b = 0; b < c_NUM_BANKS; b++) begin
                if (r_trcd[b] != 16'd0) r_trcd[b] <= r_trcd[b] - 16'd1;
            end

            if ((w_viol != ERR_NONE) && !r_error) begin
                r_error      <= 1'b1;
                r_error_code <= w_viol;
            end

            case (r_state)
                INIT_POWERUP: begin
                    if (({1'b0, r_pwr_cnt} + 17'd1) >= {1'b0, INHIBIT_CYCLES}) begin
                        r_state <= INIT_WAIT_PRECHARGE;
                    end else begin
                        r_pwr_cnt <= r_pwr_cnt + 16'd1;
                    end
                end
                INIT_WAIT_PRECHARGE: begin
                    if ((w_cmd == CMD_PRECHARGE) && sdram_addr[10]) r_state <= INIT_WAIT_MODE;
                end
                INIT_WAIT_MODE: begin
                    if (w_cmd == CMD_MODE) begin
                        r_state    <= INIT_WAIT_REFRESH;
                        r_ref_init <= 16'd0;
                    end
                end
                INIT_WAIT_REFRESH: begin
                    if (w_cmd == CMD_REFRESH) begin
                        if (({1'b0, r_ref_init} + 17'd1) >= {1'b0, INIT_REFRESHES}) begin
                            r_state <= INIT_READY;
                            r_ready <= 1'b1;
                        end else begin
                            r_ref_init <= r_ref_init + 16'd1;
                        end
                    end
                end
                default: r_state <= INIT_READY;
            endcase

            case (w_cmd)
                CMD_PRECHARGE: begin
                    r_trp_wait <= wait_load(PRECHARGE_CYCLES);
                    if (sdram_addr[10]) begin
                        for (int b = 0; b < c_NUM_BANKS; b++) r_bank_state[b] <= BANK_IDLE;
                    end else begin
                        r_bank_state[sdram_bs] <= BANK_IDLE;
                    end
                end
                CMD_REFRESH: begin
                    r_trc_wait <= wait_load(REFRESH_CYCLES);
                    if (r_refresh_count != 16'hFFFF) r_refresh_count <= r_refresh_count + 16'd1;
                end
                CMD_MODE: begin
                    if ((sdram_addr[6:4] == 3'd2) || (sdram_addr[6:4] == 3'd3)) r_cl <= sdram_addr[5:4];
                end
                CMD_ACTIVATE: begin
                    r_bank_state[sdram_bs] <= BANK_ACTIVE;
                    r_bank_row[sdram_bs]   <= sdram_addr;
                    r_trcd[sdram_bs]       <= wait_load(ACTIVATE_CYCLES);
                end
                CMD_READ, CMD_WRITE: begin
                    if (sdram_addr[10]) r_bank_state[sdram_bs] <= BANK_IDLE;
                end
                default: ;
            endcase
        end
    end

    sdram_read_pipe #(
        .ADDR_BITS (MEM_ADDR_BITS)
    ) u_read_pipe (
        .clk       (clk),
        .rst       (reset),
        .i_push    (w_cmd == CMD_READ),
        .i_addr    (w_word_addr),
        .i_dqm     (sdram_dqm),
        .i_cl      (r_cl),
        .o_valid   (w_pipe_valid),
        .o_addr    (w_pipe_addr),
        .o_dqm     (w_pipe_dqm),
        .o_pending (w_pipe_pending)
    );

    always_ff @(posedge clk) begin
        if (!reset && (w_cmd == CMD_WRITE)) begin
            if (!sdram_dqm[1]) r_mem[w_word_addr][15:8] <= sdram_data[15:8];
            if (!sdram_dqm[0]) r_mem[w_word_addr][7:0]  <= sdram_data[7:0];
        end
        r_dq <= r_mem[w_pipe_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drv          <= 2'b00;
            r_rd_out_valid <= 1'b0;
        end else begin
            r_drv          <= w_pipe_valid ? ~w_pipe_dqm : 2'b00;
            r_rd_out_valid <= w_pipe_valid;
        end
    end

    assign sdram_data[15:8] = r_drv[1] ? r_dq[15:8] : 8'hzz;
    assign sdram_data[7:0]  = r_drv[0] ? r_dq[7:0]  : 8'hzz;

    assign ready         = r_ready;
    assign cas_latency   = r_cl;
    assign error         = r_error;
    assign error_code    = r_error_code;
    assign refresh_count = r_refresh_count;

endmodule
`default_nettype wire

// File: tb/tb_sdram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_responder
// Purpose  : Directed self-checking bench for sdram_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_responder;

    localparam logic [3:0] c_MODE = 4'b0000;
    localparam logic [3:0] c_REF  = 4'b0001;
    localparam logic [3:0] c_PRE  = 4'b0010;
    localparam logic [3:0] c_ACT  = 4'b0011;
    localparam logic [3:0] c_WR   = 4'b0100;
    localparam logic [3:0] c_RD   = 4'b0101;
    localparam logic [3:0] c_NOP  = 4'b0111;

    logic        clk;
    logic        reset;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_bs;
    logic        sdram_cs, sdram_ras, sdram_cas, sdram_we;
    logic [1:0]  sdram_dqm;
    logic        sdram_cke;
    logic        ready;
    logic [1:0]  cas_latency;
    logic        error;
    logic [3:0]  error_code;
    logic [15:0] refresh_count;
    logic        tb_drv;
    logic [15:0] tb_wdata;
    // Weak pull-down: an undriven byte reads back as 8'h00.
    tri0  [15:0] sdram_data;

    assign sdram_data = tb_drv ? tb_wdata : 16'hzzzz;

    int n_total;
    int n_bad;

    sdram_responder #(
        .INHIBIT_CYCLES (16'd100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sdram_addr    (sdram_addr),
        .sdram_bs      (sdram_bs),
        .sdram_data    (sdram_data),
        .sdram_cs      (sdram_cs),
        .sdram_ras     (sdram_ras),
        .sdram_cas     (sdram_cas),
        .sdram_we      (sdram_we),
        .sdram_dqm     (sdram_dqm),
        .sdram_cke     (sdram_cke),
        .ready         (ready),
        .cas_latency   (cas_latency),
        .error         (error),
        .error_code    (error_code),
        .refresh_count (refresh_count)
    );

    initial clk = 1'b0;
    always #3 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // Every drive lands on a negedge and is sampled by the following posedge.
    task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                         input logic [1:0] m, input logic [15:0] wd, input logic drv, input logic cke);
        @(negedge clk);
        {sdram_cs, sdram_ras, sdram_cas, sdram_we} = c;
        sdram_bs   = b;
        sdram_addr = a;
        sdram_dqm  = m;
        sdram_cke  = cke;
        tb_wdata   = wd;
        tb_drv     = drv;
    endtask

    task automatic nop();
        drive(c_NOP, 2'd0, 13'd0, 2'b00, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) nop();
    endtask

    task automatic cmd(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
        drive(c, b, a, 2'b00, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic wr(input logic [1:0] b, input logic [8:0] col, input logic [15:0] d, input logic [1:0] m);
        drive(c_WR, b, {4'b0000, col}, m, d, 1'b1, 1'b1);
    endtask

    task automatic rd(input logic [1:0] b, input logic [8:0] col, input logic [1:0] m, input logic ap);
        drive(c_RD, b, {2'b00, ap, 1'b0, col}, m, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nops(3);
        reset = 1'b0;
    endtask

    task automatic do_init(input logic [12:0] mode_word);
        nops(100);
        cmd(c_PRE, 2'd0, 13'h400);
        nops(2);
        cmd(c_MODE, 2'd0, mode_word);
        nop();
        for (int i = 0; i < 8; i++) begin
            cmd(c_REF, 2'd0, 13'd0);
            nops(8);
        end
    endtask

    initial begin
        logic [15:0] exp_bus;
        n_total    = 0;
        n_bad      = 0;
        reset      = 1'b1;
        sdram_cke  = 1'b1;
        {sdram_cs, sdram_ras, sdram_cas, sdram_we} = 4'b1111;
        sdram_addr = 13'd0;
        sdram_bs   = 2'd0;
        sdram_dqm  = 2'b00;
        tb_drv     = 1'b0;
        tb_wdata   = 16'h0;

        // Reset values and legal initialisation
        do_reset();
        check_val("rst_ready", ready, 0);
        check_val("rst_cl", cas_latency, 3);
        check_val("rst_error", error, 0);
        check_val("rst_code", error_code, 0);
        check_val("rst_refcnt", refresh_count, 0);
        check_val("rst_bus", sdram_data, 16'h0000);
        do_init(13'h230);
        check_val("init_ready", ready, 1);
        check_val("init_cl", cas_latency, 3);
        check_val("init_refcnt", refresh_count, 8);
        check_val("init_error", error, 0);
        drive(c_REF, 2'd0, 13'd0, 2'b00, 16'h0, 1'b0, 1'b0);
        nop();
        check_val("cke_low_refcnt", refresh_count, 8);
        check_val("cke_low_error", error, 0);

        // Byte-masked write, CL=3 read-back, masked read, auto-precharge, contention
        do_reset();
        do_init(13'h230);
        cmd(c_ACT, 2'd1, 13'd5);
        nop();
        wr(2'd1, 9'd7, 16'h1234, 2'b00);
        wr(2'd1, 9'd7, 16'hA55A, 2'b10);
        rd(2'd1, 9'd7, 2'b00, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            nop();
            exp_bus = (k == 4) ? 16'h125A : 16'h0000;
            check_val($sformatf("cl3_rd_k%0d", k), sdram_data, exp_bus);
        end
        rd(2'd1, 9'd7, 2'b01, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            nop();
            exp_bus = (k == 4) ? 16'h1200 : 16'h0000;
            check_val($sformatf("dqm01_rd_k%0d", k), sdram_data, exp_bus);
        end
        cmd(c_ACT, 2'd1, 13'd5);
        nop();
        check_val("autopre_reopen_error", error, 0);
        rd(2'd1, 9'd7, 2'b00, 1'b0);
        wr(2'd1, 9'd8, 16'hBEEF, 2'b00);
        nop();
        check_val("contention_code", error_code, 9);

        // tRCD violation, then a sticky code across a later violation
        do_reset();
        do_init(13'h230);
        cmd(c_ACT, 2'd0, 13'd1);
        rd(2'd0, 9'd0, 2'b00, 1'b0);
        nop();
        check_val("trcd_error", error, 1);
        check_val("trcd_code", error_code, 6);
        cmd(c_ACT, 2'd0, 13'd2);
        nop();
        check_val("sticky_error", error, 1);
        check_val("sticky_code", error_code, 6);

        // REFRESH four cycles after a REFRESH
        do_reset();
        do_init(13'h230);
        cmd(c_REF, 2'd0, 13'd0);
        nops(3);
        check_val("trc_pre_error", error, 0);
        cmd(c_REF, 2'd0, 13'd0);
        nop();
        check_val("trc_error", error, 1);
        check_val("trc_code", error_code, 8);

        // CL=2 with back-to-back reads
        do_reset();
        do_init(13'h220);
        check_val("cl2_latched", cas_latency, 2);
        cmd(c_ACT, 2'd2, 13'd3);
        nop();
        wr(2'd2, 9'd0, 16'h1A01, 2'b00);
        wr(2'd2, 9'd1, 16'h2B02, 2'b00);
        wr(2'd2, 9'd2, 16'h3C03, 2'b00);
        rd(2'd2, 9'd0, 2'b00, 1'b0);
        rd(2'd2, 9'd1, 2'b00, 1'b0);
        rd(2'd2, 9'd2, 2'b00, 1'b0);
        check_val("b2b_k0", sdram_data, 16'h0000);
        for (int k = 1; k <= 4; k++) begin
            nop();
            case (k)
                1:       exp_bus = 16'h1A01;
                2:       exp_bus = 16'h2B02;
                3:       exp_bus = 16'h3C03;
                default: exp_bus = 16'h0000;
            endcase
            check_val($sformatf("b2b_k%0d", k), sdram_data, exp_bus);
        end
        check_val("b2b_error", error, 0);

        // One-cycle reset pulse right after a READ cancels its data
        do_reset();
        do_init(13'h230);
        cmd(c_ACT, 2'd3, 13'd0);
        nop();
        wr(2'd3, 9'd5, 16'h7E7E, 2'b00);
        rd(2'd3, 9'd5, 2'b00, 1'b0);
        nop();
        reset = 1'b1;
        nop();
        check_val("rstrd_bus_k2", sdram_data, 16'h0000);
        check_val("rstrd_ready", ready, 0);
        reset = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            nop();
            check_val($sformatf("rstrd_bus_k%0d", k), sdram_data, 16'h0000);
        end
        check_val("rstrd_cl", cas_latency, 3);
        check_val("rstrd_refcnt", refresh_count, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
